elevator_ctrl_param: RTL and testbench

Parametrised single-car elevator controller, the next-generation replacement for the fixed five-floor controller. It supports NUM_FLOORS floors, multi-cycle floor travel, a timed door-open phase and SCAN (keep-direction) scheduling. Car and hall call buttons are merged into one pending-request vector. It sits between the button/sensor front end and the motor/door drivers.

---
 rtl/elevator_ctrl_param_if.sv | 26 ++
 rtl/elevator_ctrl_param.sv | 124 ++++++++++++
 tb/tb_elevator_ctrl_param.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_ctrl_param_if.sv
// Button/sensor front end <-> elevator controller bundle.
// The master drives requests; the slave (the controller) drives car status.
interface elevator_ctrl_param_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] floor;
    logic [NUM_FLOORS-1:0] up;
    logic [NUM_FLOORS-1:0] down;
    logic [FLOOR_W-1:0]    floor_number;
    logic [NUM_FLOORS-1:0] to_go;
    logic                  move;
    logic                  dir;
    logic                  door_open;
    logic                  arrived;

    modport master (
        output floor, up, down,
        input  floor_number, to_go, move, dir, door_open, arrived
    );

    modport slave (
        input  floor, up, down,
        output floor_number, to_go, move, dir, door_open, arrived
    );
endinterface

// File: rtl/elevator_ctrl_param.sv
// Single-car SCAN elevator controller: merged request vector, timed floor
// travel and door phase, all outputs registered.
//   state  | meaning
//   IDLE   | car parked, choosing door / direction
//   MOVING | travelling, floor steps at travel terminal count
//   DOOR   | stopped with door open for DOOR_CYCLES cycles
module elevator_ctrl_param #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    elevator_ctrl_param_if.slave  bus
);
    localparam int TRV_W  = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;

    state_t                state_q;
    logic [FLOOR_W-1:0]    floor_q;
    logic [NUM_FLOORS-1:0] to_go_q, to_go_d;
    logic                  dir_q, move_q, door_q, arrived_q;
    logic [TRV_W-1:0]      travel_cnt_q;
    logic [DOOR_W-1:0]     door_cnt_q;

    logic                  above, below, travel_tc, door_tc, stop_here, stop_next;
    logic [FLOOR_W-1:0]    next_floor;
    logic [NUM_FLOORS-1:0] clear_mask;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor_q)) above = above | to_go_q[i];
            if (i < int'(floor_q)) below = below | to_go_q[i];
        end
        travel_tc  = (travel_cnt_q == TRV_W'(TRAVEL_CYCLES - 1));
        door_tc    = (door_cnt_q == DOOR_W'(DOOR_CYCLES - 1));
        next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        stop_here  = to_go_q[floor_q];
        stop_next  = to_go_q[next_floor];
        // DOOR masks its own floor every cycle so repeat presses are absorbed
        clear_mask = '0;
        case (state_q)
            IDLE:    if (stop_here) clear_mask[floor_q] = 1'b1;
            MOVING:  if (travel_tc && stop_next) clear_mask[next_floor] = 1'b1;
            DOOR:    clear_mask[floor_q] = 1'b1;
            default: clear_mask = '0;
        endcase
        to_go_d = (to_go_q | bus.floor | bus.up | bus.down) & ~clear_mask;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            to_go_q      <= '0;
            dir_q        <= 1'b1;
            move_q       <= 1'b0;
            door_q       <= 1'b0;
            arrived_q    <= 1'b0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
        end else begin
            to_go_q   <= to_go_d;
            arrived_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (stop_here) begin
                        state_q    <= DOOR;
                        door_q     <= 1'b1;
                        door_cnt_q <= '0;
                    end else if (above || below) begin
                        // Keep direction when work lies on both sides
                        if (!(above && below)) dir_q <= above;
                        state_q      <= MOVING;
                        move_q       <= 1'b1;
                        travel_cnt_q <= '0;
                    end
                end
                MOVING: begin
                    if (travel_tc) begin
                        floor_q      <= next_floor;
                        travel_cnt_q <= '0;
                        arrived_q    <= 1'b1;
                        if (stop_next) begin
                            state_q    <= DOOR;
                            move_q     <= 1'b0;
                            door_q     <= 1'b1;
                            door_cnt_q <= '0;
                        end
                    end else begin
                        travel_cnt_q <= travel_cnt_q + TRV_W'(1);
                    end
                end
                DOOR: begin
                    if (door_tc) begin
                        state_q <= IDLE;
                        door_q  <= 1'b0;
                    end else begin
                        door_cnt_q <= door_cnt_q + DOOR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && state_q == MOVING && travel_tc)
            assert (dir_q ? (floor_q != FLOOR_W'(NUM_FLOORS - 1)) : (floor_q != '0))
            else $error("car stepped past the end of the shaft");
    end

    assign bus.floor_number = floor_q;
    assign bus.to_go        = to_go_q;
    assign bus.move         = move_q;
    assign bus.dir          = dir_q;
    assign bus.door_open    = door_q;
    assign bus.arrived      = arrived_q;
endmodule

// File: tb/tb_elevator_ctrl_param.sv
// Scoreboard bench for elevator_ctrl_param: directed requests push expected
// arrivals/door openings; a negedge monitor pops and compares them.
module tb_elevator_ctrl_param;
    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TC = 4;
    localparam int DC = 3;

    typedef struct {
        int fl;
        int cy;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  arr_q[$];
    ev_t  door_q[$];
    ev_t  mon_e;
    logic door_prev = 1'b0;
    int   door_start = 0;

    elevator_ctrl_param_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_ctrl_param #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    task automatic exp_arr(input int fl, input int cy);
        arr_q.push_back('{fl: fl, cy: cy});
    endtask

    task automatic exp_door(input int fl, input int cy);
        door_q.push_back('{fl: fl, cy: cy});
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] f, input logic [7:0] u, input logic [7:0] d,
                         output int e);
        bus.floor = f;
        bus.up    = u;
        bus.down  = d;
        e = cyc + 1;
        @(negedge clk);
        bus.floor = '0;
        bus.up    = '0;
        bus.down  = '0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (arr_q.size() == 0 && door_q.size() == 0 &&
                bus.move === 1'b0 && bus.door_open === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout pending_arr=%0d pending_door=%0d cycle=%0d",
                     arr_q.size(), door_q.size(), cyc);
        end
    endtask

    // Monitor: every arrival pulse and door opening must match the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            door_prev = 1'b0;
        end else begin
            if (bus.arrived === 1'b1) begin
                chk("floor_range", (int'(bus.floor_number) < NF), 1);
                if (arr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_arrival actual=floor %0d required=none cycle=%0d",
                             bus.floor_number, cyc);
                end else begin
                    mon_e = arr_q.pop_front();
                    chk("arrive_floor", bus.floor_number, mon_e.fl);
                    chk("arrive_cycle", cyc, mon_e.cy);
                end
            end
            if (bus.door_open === 1'b1 && !door_prev) begin
                door_start = cyc;
                if (door_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_door actual=floor %0d required=none cycle=%0d",
                             bus.floor_number, cyc);
                end else begin
                    mon_e = door_q.pop_front();
                    chk("door_floor", bus.floor_number, mon_e.fl);
                    chk("door_cycle", cyc, mon_e.cy);
                end
            end
            if (bus.door_open === 1'b0 && door_prev)
                chk("door_len", cyc - door_start, DC);
            door_prev = bus.door_open;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, f, g, h, j, x;
        bus.floor = 8'hFF;
        bus.up    = '0;
        bus.down  = '0;
        rst       = 1'b1;

        // Reset with every car button held
        repeat (3) @(negedge clk);
        chk("rst_floor_number", bus.floor_number, 0);
        chk("rst_to_go", bus.to_go, 8'h00);
        chk("rst_move", bus.move, 0);
        chk("rst_dir", bus.dir, 1);
        chk("rst_door", bus.door_open, 0);
        chk("rst_arrived", bus.arrived, 0);
        rst = 1'b0;
        bus.floor = '0;
        repeat (2) @(negedge clk);
        chk("post_rst_to_go", bus.to_go, 8'h00);

        // 0 -> 3, plus a press of floor 3 during the door phase
        pulse(8'h08, 8'h00, 8'h00, e);
        exp_arr(1, e + 5);
        exp_arr(2, e + 9);
        exp_arr(3, e + 13);
        exp_door(3, e + 13);
        chk("to_go_latched", bus.to_go, 8'h08);
        wait_until(e + 1);
        chk("depart_move", bus.move, 1);
        chk("depart_dir", bus.dir, 1);
        wait_until(e + 14);
        pulse(8'h08, 8'h00, 8'h00, x);
        chk("absorb_to_go", bus.to_go, 8'h00);
        chk("absorb_door", bus.door_open, 1);
        wait_idle(60);
        repeat (3) @(negedge clk);
        chk("at3_floor", bus.floor_number, 3);
        chk("at3_to_go", bus.to_go, 8'h00);
        chk("at3_move", bus.move, 0);

        // SCAN: up[6] first, down[1] injected at floor 4
        pulse(8'h00, 8'h40, 8'h00, f);
        exp_arr(4, f + 5);
        exp_arr(5, f + 9);
        exp_arr(6, f + 13);
        exp_door(6, f + 13);
        exp_arr(5, f + 21);
        exp_arr(4, f + 25);
        exp_arr(3, f + 29);
        exp_arr(2, f + 33);
        exp_arr(1, f + 37);
        exp_door(1, f + 37);
        wait_until(f + 5);
        chk("scan_at4", bus.floor_number, 4);
        pulse(8'h00, 8'h00, 8'h02, x);
        chk("scan_to_go", bus.to_go, 8'h42);
        wait_until(f + 13);
        chk("scan_no_reverse_dir", bus.dir, 1);
        wait_until(f + 16);
        chk("scan_idle_gap_move", bus.move, 0);
        chk("scan_idle_gap_door", bus.door_open, 0);
        wait_until(f + 17);
        chk("scan_reverse_dir", bus.dir, 0);
        chk("scan_reverse_move", bus.move, 1);
        wait_idle(80);
        repeat (2) @(negedge clk);

        // Travel to the top floor
        pulse(8'h80, 8'h00, 8'h00, g);
        for (int k = 1; k <= 6; k++) exp_arr(1 + k, g + 1 + k * TC);
        exp_door(7, g + 25);
        wait_idle(80);
        repeat (2) @(negedge clk);
        chk("at7_floor", bus.floor_number, 7);

        // Both ends at once while parked at the top
        pulse(8'h81, 8'h00, 8'h00, h);
        exp_door(7, h + 1);
        for (int k = 1; k <= 7; k++) exp_arr(7 - k, h + 5 + k * TC);
        exp_door(0, h + 33);
        wait_until(h + 1);
        chk("ends_door_first", bus.door_open, 1);
        chk("ends_to_go", bus.to_go, 8'h01);
        wait_until(h + 5);
        chk("ends_down_dir", bus.dir, 0);
        wait_idle(80);
        repeat (2) @(negedge clk);
        chk("at0_floor", bus.floor_number, 0);

        // Reset mid-travel between floors 2 and 3
        pulse(8'h80, 8'h00, 8'h00, j);
        exp_arr(1, j + 5);
        exp_arr(2, j + 9);
        wait_until(j + 10);
        chk("mid_to_go", bus.to_go, 8'h80);
        chk("mid_move", bus.move, 1);
        chk("mid_floor", bus.floor_number, 2);
        rst = 1'b1;
        bus.floor = 8'h01;
        @(negedge clk);
        chk("mrst_floor_number", bus.floor_number, 0);
        chk("mrst_to_go", bus.to_go, 8'h00);
        chk("mrst_move", bus.move, 0);
        chk("mrst_dir", bus.dir, 1);
        chk("mrst_door", bus.door_open, 0);
        chk("mrst_arrived", bus.arrived, 0);
        rst = 1'b0;
        bus.floor = '0;
        repeat (12) @(negedge clk);
        chk("mrst_stay_move", bus.move, 0);
        chk("mrst_stay_floor", bus.floor_number, 0);
        chk("mrst_stay_to_go", bus.to_go, 8'h00);
        chk("arr_q_left", arr_q.size(), 0);
        chk("door_q_left", door_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
